// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron predictor: weight geometry, the
// trainer state encoding, and weight-field slicing used by the trainer and
// the Wallace sum units.
package perceptron_pkg;

  localparam int NUM_WEIGHTS = 12;
  localparam int WEIGHT_W    = 4;
  localparam int ROW_W       = NUM_WEIGHTS * WEIGHT_W;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_READ   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Weight i of a packed row lives at bits [i*WEIGHT_W +: WEIGHT_W].
  function automatic logic [WEIGHT_W-1:0] get_field(input logic [ROW_W-1:0] row,
                                                    input int unsigned i);
    return row[i*WEIGHT_W +: WEIGHT_W];
  endfunction

endpackage

// File: rtl/sat_weight_update.sv
// Single-weight saturating +1/-1 step. The weight never wraps: it holds at
// the all-ones maximum on increment and at zero on decrement.
module sat_weight_update
  import perceptron_pkg::*;
(
  input  logic [WEIGHT_W-1:0] w,
  input  logic                inc,
  output logic [WEIGHT_W-1:0] w_next
);

  localparam logic [WEIGHT_W-1:0] W_MAX = {WEIGHT_W{1'b1}};
  localparam logic [WEIGHT_W-1:0] W_MIN = {WEIGHT_W{1'b0}};
  localparam logic [WEIGHT_W-1:0] W_ONE = {{(WEIGHT_W-1){1'b0}}, 1'b1};

  // Saturating step in the direction selected by inc.
  always_comb begin
    w_next = w;
    if (inc) begin
      if (w == W_MAX) begin
        w_next = w;
      end else begin
        w_next = w + W_ONE;
      end
    end else begin
      if (w == W_MIN) begin
        w_next = w;
      end else begin
        w_next = w - W_ONE;
      end
    end
  end

endmodule

// File: rtl/perceptron_weight_trainer.sv
// Owner of the perceptron weight table. Clears the table to INIT_W after
// reset, serves a registered read port with write-first bypass, and applies
// saturating per-weight training updates as a read-modify-write of one row.
// Confident correct predictions retire without touching the table.
module perceptron_weight_trainer
  import perceptron_pkg::*;
#(
  parameter int TABLE_DEPTH = 64,
  parameter int IDX_W       = 6,
  parameter int INIT_W      = 8
)
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   train_valid,
  output logic                   train_ready,
  input  logic [IDX_W-1:0]       train_idx,
  input  logic [NUM_WEIGHTS-1:0] train_hist,
  input  logic                   train_taken,
  input  logic                   train_pred,
  input  logic                   train_confident,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [ROW_W-1:0]       rd_weights,
  output logic                   upd_done,
  output logic                   upd_written,
  output logic                   init_busy
);

  localparam logic [WEIGHT_W-1:0] INIT_FIELD = WEIGHT_W'(INIT_W);
  localparam logic [ROW_W-1:0]    INIT_ROW   = {NUM_WEIGHTS{INIT_FIELD}};
  localparam logic [IDX_W-1:0]    LAST_ROW   = IDX_W'(TABLE_DEPTH - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};

  state_t                 state;
  logic [IDX_W-1:0]       clr_ptr;
  logic [IDX_W-1:0]       idx_r;
  logic [NUM_WEIGHTS-1:0] hist_r;
  logic                   taken_r;
  logic [ROW_W-1:0]       row_r;
  logic [ROW_W-1:0]       new_r;
  logic [ROW_W-1:0]       new_row;
  logic                   skip;
  logic [ROW_W-1:0]       mem [TABLE_DEPTH];

  // A confident correct prediction needs no training.
  assign skip = (train_pred == train_taken) && train_confident;

  // One saturating updater per weight: strengthen when the history bit
  // agrees with the outcome, weaken otherwise.
  for (genvar g = 0; g < NUM_WEIGHTS; g++) begin : g_upd
    sat_weight_update u_sat (
      .w      (get_field(row_r, g)),
      .inc    (hist_r[g] == taken_r),
      .w_next (new_row[g*WEIGHT_W +: WEIGHT_W])
    );
  end

  // Table storage: clear sweep during CLEAR, row commit during WRITE.
  // Writes are suppressed while reset is asserted so an aborted request
  // never lands in the table.
  always_ff @(posedge clk) begin
    if (reset_n && (state == ST_CLEAR)) begin
      mem[clr_ptr] <= INIT_ROW;
    end else if (reset_n && (state == ST_WRITE)) begin
      mem[idx_r] <= new_r;
    end
  end

  // Training FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_CLEAR;
      clr_ptr     <= '0;
      idx_r       <= '0;
      hist_r      <= '0;
      taken_r     <= 1'b0;
      row_r       <= '0;
      new_r       <= '0;
      train_ready <= 1'b0;
      upd_done    <= 1'b0;
      upd_written <= 1'b0;
      init_busy   <= 1'b1;
    end else begin
      upd_done    <= 1'b0;
      upd_written <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (clr_ptr == LAST_ROW) begin
            state       <= ST_IDLE;
            train_ready <= 1'b1;
            init_busy   <= 1'b0;
          end else begin
            clr_ptr <= clr_ptr + IDX_ONE;
          end
        end
        ST_IDLE: begin
          if (train_valid) begin
            idx_r       <= train_idx;
            hist_r      <= train_hist;
            taken_r     <= train_taken;
            train_ready <= 1'b0;
            if (skip) begin
              state    <= ST_DONE;
              upd_done <= 1'b1;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          row_r <= mem[idx_r];
          state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          new_r       <= new_row;
          state       <= ST_WRITE;
          upd_done    <= 1'b1;
          upd_written <= 1'b1;
        end
        ST_WRITE: begin
          state       <= ST_IDLE;
          train_ready <= 1'b1;
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          train_ready <= 1'b1;
        end
        default: begin
          state       <= ST_CLEAR;
          clr_ptr     <= '0;
          train_ready <= 1'b0;
          init_busy   <= 1'b1;
        end
      endcase
    end
  end

  // Registered predictor read port; the row being committed this cycle is
  // forwarded so the predictor never sees stale weights.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_weights <= '0;
    end else if (state == ST_CLEAR) begin
      rd_weights <= INIT_ROW;
    end else if ((state == ST_WRITE) && (rd_idx == idx_r)) begin
      rd_weights <= new_r;
    end else begin
      rd_weights <= mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_perceptron_weight_trainer.sv
// Directed self-checking bench for perceptron_weight_trainer.
module tb_perceptron_weight_trainer;

  logic        clk;
  logic        reset_n;
  logic        train_valid;
  logic        train_ready;
  logic [5:0]  train_idx;
  logic [11:0] train_hist;
  logic        train_taken;
  logic        train_pred;
  logic        train_confident;
  logic [5:0]  rd_idx;
  logic [47:0] rd_weights;
  logic        upd_done;
  logic        upd_written;
  logic        init_busy;

  int checks;
  int failures;
  logic [47:0] rd_at_wr;
  logic [47:0] rd_after_wr;

  localparam logic [47:0] ROW_INIT = 48'h888888888888;

  perceptron_weight_trainer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .train_valid     (train_valid),
    .train_ready     (train_ready),
    .train_idx       (train_idx),
    .train_hist      (train_hist),
    .train_taken     (train_taken),
    .train_pred      (train_pred),
    .train_confident (train_confident),
    .rd_idx          (rd_idx),
    .rd_weights      (rd_weights),
    .upd_done        (upd_done),
    .upd_written     (upd_written),
    .init_busy       (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and check the handshake timing. Called at a negedge.
  task automatic do_train(input logic [5:0] idx, input logic [11:0] hist,
                          input logic taken, input logic pred, input logic conf,
                          input logic exp_skip);
    int n;
    n = 0;
    while (train_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (train_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_wait: train_ready=%b required 1", train_ready);
    end
    train_idx = idx; train_hist = hist; train_taken = taken;
    train_pred = pred; train_confident = conf; train_valid = 1'b1;
    @(negedge clk); // T+1
    train_valid = 1'b0;
    checks++;
    if (upd_done !== exp_skip || upd_written !== 1'b0 || train_ready !== 1'b0) begin
      failures++;
      $display("FAIL t1_status: done=%b written=%b ready=%b required %b 0 0",
               upd_done, upd_written, train_ready, exp_skip);
    end
    if (!exp_skip) begin
      @(negedge clk); // T+2
      checks++;
      if (upd_done !== 1'b0 || train_ready !== 1'b0) begin
        failures++;
        $display("FAIL t2_status: done=%b ready=%b required 0 0", upd_done, train_ready);
      end
      @(negedge clk); // T+3
      rd_at_wr = rd_weights;
      checks++;
      if (upd_done !== 1'b1 || upd_written !== 1'b1 || train_ready !== 1'b0) begin
        failures++;
        $display("FAIL t3_write: done=%b written=%b ready=%b required 1 1 0",
                 upd_done, upd_written, train_ready);
      end
    end
    @(negedge clk); // T+2 (skip) or T+4 (update)
    rd_after_wr = rd_weights;
    checks++;
    if (train_ready !== 1'b1 || upd_done !== 1'b0) begin
      failures++;
      $display("FAIL ready_back: ready=%b done=%b required 1 0", train_ready, upd_done);
    end
  endtask

  // Registered read of one row. Called at a negedge.
  task automatic read_row(input logic [5:0] idx, output logic [47:0] data);
    rd_idx = idx;
    @(negedge clk);
    data = rd_weights;
  endtask

  task automatic test_reset();
    int cnt;
    int bad_ready;
    int bad_rd;
    logic [47:0] d;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (train_ready !== 1'b0 || upd_done !== 1'b0 || upd_written !== 1'b0 ||
        init_busy !== 1'b1 || rd_weights !== 48'h0) begin
      failures++;
      $display("FAIL reset_vals: ready=%b done=%b written=%b busy=%b rd=%h required 0 0 0 1 0",
               train_ready, upd_done, upd_written, init_busy, rd_weights);
    end
    reset_n = 1'b1;
    cnt = 1; bad_ready = 0; bad_rd = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (init_busy !== 1'b1) break;
      cnt++;
      if (train_ready !== 1'b0) bad_ready++;
      if (rd_weights !== ROW_INIT) bad_rd++;
    end
    checks++;
    if (cnt != 64) begin
      failures++;
      $display("FAIL init_busy_len: cycles=%0d required 64", cnt);
    end
    checks++;
    if (bad_ready != 0 || bad_rd != 0) begin
      failures++;
      $display("FAIL clear_outputs: ready_hi=%0d rd_not_init=%0d required 0 0", bad_ready, bad_rd);
    end
    checks++;
    if (train_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready: ready=%b required 1", train_ready);
    end
    read_row(6'd0, d);
    checks++;
    if (d !== ROW_INIT) begin failures++; $display("FAIL init_row0: got %h required %h", d, ROW_INIT); end
    read_row(6'd37, d);
    checks++;
    if (d !== ROW_INIT) begin failures++; $display("FAIL init_row37: got %h required %h", d, ROW_INIT); end
    read_row(6'd63, d);
    checks++;
    if (d !== ROW_INIT) begin failures++; $display("FAIL init_row63: got %h required %h", d, ROW_INIT); end
  endtask

  task automatic test_mispredict();
    logic [47:0] d;
    do_train(6'd5, 12'hFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    read_row(6'd5, d);
    checks++;
    if (d !== 48'h999999999999) begin failures++; $display("FAIL mispredict_row5: got %h required 999999999999", d); end
    read_row(6'd6, d);
    checks++;
    if (d !== ROW_INIT) begin failures++; $display("FAIL neighbour_row6: got %h required %h", d, ROW_INIT); end
  endtask

  task automatic test_saturation();
    logic [47:0] d;
    for (int k = 0; k < 7; k++) do_train(6'd3, 12'hFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    read_row(6'd3, d);
    checks++;
    if (d !== 48'hFFFFFFFFFFFF) begin failures++; $display("FAIL sat_up_7: got %h required ffffffffffff", d); end
    do_train(6'd3, 12'hFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    do_train(6'd3, 12'hFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    read_row(6'd3, d);
    checks++;
    if (d !== 48'hFFFFFFFFFFFF) begin failures++; $display("FAIL sat_up_hold: got %h required ffffffffffff", d); end
    for (int k = 0; k < 7; k++) do_train(6'd4, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    read_row(6'd4, d);
    checks++;
    if (d !== 48'h111111111111) begin failures++; $display("FAIL sat_dn_7: got %h required 111111111111", d); end
    do_train(6'd4, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    read_row(6'd4, d);
    checks++;
    if (d !== 48'h000000000000) begin failures++; $display("FAIL sat_dn_8: got %h required 000000000000", d); end
    do_train(6'd4, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    read_row(6'd4, d);
    checks++;
    if (d !== 48'h000000000000) begin failures++; $display("FAIL sat_dn_hold: got %h required 000000000000", d); end
  endtask

  task automatic test_skip();
    logic [47:0] d;
    do_train(6'd5, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1);
    read_row(6'd5, d);
    checks++;
    if (d !== 48'h999999999999) begin failures++; $display("FAIL skip_row5: got %h required 999999999999", d); end
    // Correct but unconfident still trains.
    do_train(6'd9, 12'h0F0, 1'b1, 1'b1, 1'b0, 1'b0);
    read_row(6'd9, d);
    checks++;
    if (d !== 48'h777799997777) begin failures++; $display("FAIL unconfident_row9: got %h required 777799997777", d); end
  endtask

  task automatic test_bypass();
    logic [47:0] d;
    rd_idx = 6'd7;
    do_train(6'd7, 12'hA5A, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (rd_at_wr !== ROW_INIT) begin failures++; $display("FAIL bypass_before: got %h required %h", rd_at_wr, ROW_INIT); end
    checks++;
    if (rd_after_wr !== 48'h797997977979) begin failures++; $display("FAIL bypass_new: got %h required 797997977979", rd_after_wr); end
    read_row(6'd7, d);
    checks++;
    if (d !== 48'h797997977979) begin failures++; $display("FAIL mixed_row7: got %h required 797997977979", d); end
  endtask

  task automatic test_reset_midop();
    int done_seen;
    int n;
    logic [47:0] d;
    train_idx = 6'd10; train_hist = 12'hFFF; train_taken = 1'b1;
    train_pred = 1'b0; train_confident = 1'b0; train_valid = 1'b1;
    @(negedge clk); // T+1 (READ)
    train_valid = 1'b0;
    @(negedge clk); // T+2 (UPDATE)
    reset_n = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (upd_done !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0 || init_busy !== 1'b1) begin
      failures++;
      $display("FAIL midop_abort: done_pulses=%0d busy=%b required 0 1", done_seen, init_busy);
    end
    reset_n = 1'b1;
    n = 0;
    while (init_busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      if (upd_done !== 1'b0) done_seen++;
      n++;
    end
    checks++;
    if (init_busy !== 1'b0 || done_seen != 0) begin
      failures++;
      $display("FAIL midop_clear: busy=%b done_pulses=%0d required 0 0", init_busy, done_seen);
    end
    read_row(6'd10, d);
    checks++;
    if (d !== ROW_INIT) begin failures++; $display("FAIL midop_row10: got %h required %h", d, ROW_INIT); end
    read_row(6'd5, d);
    checks++;
    if (d !== ROW_INIT) begin failures++; $display("FAIL midop_row5: got %h required %h", d, ROW_INIT); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; train_valid = 1'b0; train_idx = 6'd0; train_hist = 12'h000;
    train_taken = 1'b0; train_pred = 1'b0; train_confident = 1'b0; rd_idx = 6'd0;
    rd_at_wr = '0; rd_after_wr = '0;
    test_reset();
    test_mispredict();
    test_saturation();
    test_skip();
    test_bypass();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perceptron_weight_trainer.md
Name: perceptron_weight_trainer

Overview:
Training-side writer for the perceptron branch predictor's weight table. The Wallace sum units read NUM_WEIGHTS packed unsigned weights per row. This block owns that table and serves the predictor a registered read port. On each resolved branch it performs a read-modify-write of one row, applying per-weight saturating ±1 updates.

Parameters:
NUM_WEIGHTS, 12, weights per row; one history bit per weight.
WEIGHT_W, 4, bits per unsigned weight; range 0..2^WEIGHT_W-1.
TABLE_DEPTH, 64, number of rows; must be a power of 2.
IDX_W, 6, log2(TABLE_DEPTH).
INIT_W, 8, weight value loaded into every field on reset; must be below 2^WEIGHT_W.

Ports:
clk  in  1  single clock; all logic on posedge.
reset_n  in  1  synchronous, active-low reset.
train_valid  in  1  training request valid.
train_ready  out  1  high only in IDLE.
train_idx  in  IDX_W  row to train.
train_hist  in  NUM_WEIGHTS  global history; bit i pairs with weight i.
train_taken  in  1  resolved outcome.
train_pred  in  1  prediction that was issued.
train_confident  in  1  sum-unit threshold flag for this prediction.
rd_idx  in  IDX_W  predictor read index.
rd_weights  out  NUM_WEIGHTS*WEIGHT_W  row at rd_idx, registered; weight i is bits [i*WEIGHT_W +: WEIGHT_W].
upd_done  out  1  one-cycle pulse when a request retires.
upd_written  out  1  qualifies upd_done: 1 = row was modified.
init_busy  out  1  high while the table is being initialised.

Behaviour:
- Reset (reset_n=0 at a clock edge): FSM goes to CLEAR, clear pointer = 0. Output values: train_ready=0, upd_done=0, upd_written=0, init_busy=1, rd_weights=0. Reset asserted mid-operation aborts the in-flight request with no upd_done and restarts CLEAR.
- CLEAR: writes row ptr = all fields INIT_W, one row per cycle, TABLE_DEPTH cycles. On the last row it moves to IDLE and deasserts init_busy on the following cycle. During CLEAR, rd_weights = all fields INIT_W.
- IDLE: train_ready=1. On train_valid&train_ready (cycle T), latch idx, hist, taken, pred, confident.
  - Skip path: if pred==taken and confident=1, go to DONE. upd_done=1, upd_written=0 at T+1. Table is unchanged.
  - Otherwise, go to READ.
- READ (T+1): latch the row at idx.
- UPDATE (T+2): per weight i, compute the new value:
  - if hist[i]==taken: w+1, saturating at 2^WEIGHT_W-1;
  - else: w-1, saturating at 0.
  - Computed in parallel, registered.
- WRITE (T+3): commit the row. upd_done=1, upd_written=1 in this cycle. Return to IDLE, so train_ready=1 at T+4.
- train_ready is 0 in every state except IDLE. Requests are never dropped: the source holds valid until accepted.
- Read port: rd_weights at cycle N+1 reflects rd_idx sampled at N. If WRITE at N targets rd_idx, the newly written data is returned (write-first bypass).
- Skip path latency: 1 cycle accept-to-done. Update path: 3 cycles. Throughput: one request per 2 cycles on the skip path, per 4 cycles on the update path.
- No arithmetic wraps; every weight stays within 0..2^WEIGHT_W-1.

Decomposition:
- Shared package perceptron_pkg holds NUM_WEIGHTS, WEIGHT_W, the state encoding (CLEAR, IDLE, READ, UPDATE, WRITE, DONE), and the weight-field slicing function. The Wallace sum units use the same package.
- Sub-module sat_weight_update: inputs w[WEIGHT_W-1:0], inc; output w_next, saturating. Instantiated NUM_WEIGHTS times in a generate loop.

Test Plan:
- Reset then idle: reset_n low 1 cycle -> init_busy=1 for 64 cycles, train_ready=0. Afterwards, reading any rd_idx returns 0x888888888888.
- Mispredict update: idx=5, hist=0xFFF, taken=1, pred=0 -> upd_done and upd_written at T+3, train_ready at T+4. Row 5 reads 0x999999999999.
- Saturation: 8 consecutive identical taken=1/hist=0xFFF trainings on row 3 -> fields reach 0xF and hold at 0xF on further training. Opposite training with hist=0x000 from INIT_W 8 times -> 0x0, and a 9th stays 0x0.
- Skip path: pred==taken=1, confident=1 -> upd_done=1, upd_written=0 at T+1. Row unchanged, train_ready at T+2.
- Mixed history and read bypass: hist=0xA5A, taken=0 on row 7. Hold rd_idx=7 -> in the WRITE cycle rd_weights returns the new row next cycle: fields with a 0 history bit become 9, fields with a 1 history bit become 7.
- Reset mid-op: reset_n low during UPDATE -> no upd_done, CLEAR restarts, and the target row reads INIT_W afterwards.
